// File: rtl/hilo_muldiv_if.sv
// HI/LO multiply-divide unit request/result bundle.
interface hilo_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic        hi_we;
  logic [31:0] hi_data;
  logic        lo_we;
  logic [31:0] lo_data;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, stall_req, done,
    input  hi_we, hi_data, lo_we, lo_data
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, stall_req, done,
    output hi_we, hi_data, lo_we, lo_data
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO.
// MULT_FAST_EN: single-cycle multiply instead of 32-step shift-add.
module hilo_muldiv (
  input logic         clk,
  input logic         rst,
  hilo_muldiv_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [32:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] m_q;
  logic [31:0] a_q;
  logic        mul_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic        div0_q;

  logic        sgn;
  logic        accept;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_tmp;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;

  assign sgn    = ~bus.op[0];
  assign accept = (state_q == S_IDLE) & bus.start & ~bus.cancel;
  assign mag_a  = (sgn & bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign mag_b  = (sgn & bus.src_b[31]) ? -bus.src_b : bus.src_b;

  // Shift-add step: hi accumulates, multiplier shifts out of lo.
  assign mul_sum = lo_q[0] ? hi_q + {1'b0, m_q} : hi_q;

  // Restoring step: quotient bits shift into lo as dividend leaves.
  assign div_tmp  = {hi_q[31:0], lo_q[31]};
  assign div_diff = div_tmp - {1'b0, m_q};
  assign div_ge   = div_tmp >= {1'b0, m_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.op[1]) state_d = S_DIV;
`ifdef MULT_FAST_EN
          else           state_d = S_DONE;
`else
          else           state_d = S_MUL;
`endif
        end
      end
      S_MUL, S_DIV: begin
        if (bus.cancel)         state_d = S_IDLE;
        else if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      a_q     <= '0;
      mul_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q   <= '0;
            a_q     <= bus.src_a;
            mul_q   <= ~bus.op[1];
            neg_q_q <= sgn & (bus.src_a[31] ^ bus.src_b[31]);
            neg_r_q <= sgn & bus.src_a[31];
            div0_q  <= bus.src_b == 32'd0;
            if (bus.op[1]) begin
              hi_q <= '0;
              lo_q <= mag_a;
              m_q  <= mag_b;
            end else begin
`ifdef MULT_FAST_EN
              hi_q <= {1'b0, prod[63:32]};
              lo_q <= prod[31:0];
`else
              hi_q <= '0;
              lo_q <= mag_b;
              m_q  <= mag_a;
`endif
            end
          end
        end
        S_MUL: begin
          hi_q  <= {1'b0, mul_sum[32:1]};
          lo_q  <= {mul_sum[0], lo_q[31:1]};
          cnt_q <= cnt_q + 5'd1;
        end
        S_DIV: begin
          hi_q  <= div_ge ? div_diff : div_tmp;
          lo_q  <= {lo_q[30:0], div_ge};
          cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_FAST_EN
  assign prod = {32'd0, mag_a} * {32'd0, mag_b};
`else
  assign prod = {hi_q[31:0], lo_q};
`endif

  assign quo = neg_q_q ? -lo_q : lo_q;
  assign rem = neg_r_q ? -hi_q[31:0] : hi_q[31:0];

  always_comb begin
    bus.done    = 1'b0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;
    bus.hi_data = '0;
    bus.lo_data = '0;
    if (state_q == S_DONE) begin
      bus.done  = 1'b1;
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      if (mul_q) begin
        {bus.hi_data, bus.lo_data} = neg_q_q ?
          -{hi_q[31:0], lo_q} : {hi_q[31:0], lo_q};
      end else if (div0_q) begin
        bus.hi_data = a_q;
        bus.lo_data = 32'hFFFF_FFFF;
      end else begin
        bus.hi_data = rem;
        bus.lo_data = quo;
      end
    end
  end

  assign bus.busy      = state_q != S_IDLE;
  assign bus.stall_req = ((state_q == S_IDLE) & bus.start) |
                         (state_q == S_MUL) | (state_q == S_DIV);

endmodule
